// File: rtl/mac_operand_sequencer_pkg.sv
// Shared sizing, FSM state type and FIFO entry layout for the MAC operand sequencer.
package mac_operand_sequencer_pkg;

   localparam int DATA_W    = 16;
   localparam int GROUP_LEN = 4;
   localparam int DEPTH     = 8;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAD
   } seq_state_t;

   typedef struct packed {
      logic              last;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } fifo_entry_t;

endpackage

// File: rtl/mac_operand_sequencer_if.sv
// Operand stream in, MAC slot stream out; master is the environment, slave the sequencer.
interface mac_operand_sequencer_if;
   import mac_operand_sequencer_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_a;
   logic [DATA_W-1:0] in_b;
   logic              in_last;
   logic              out_stall;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic              ce;
   logic              grp_first;
   logic              grp_last;
   logic              frame_done;

   modport master (
      output in_valid, in_a, in_b, in_last, out_stall,
      input  in_ready, a, b, ce, grp_first, grp_last, frame_done
   );

   modport slave (
      input  in_valid, in_a, in_b, in_last, out_stall,
      output in_ready, a, b, ce, grp_first, grp_last, frame_done
   );
endinterface

// File: rtl/mac_operand_sequencer_sync_fifo.sv
// Register-array FIFO holding {last,a,b}; the head is visible as soon as an entry lands.
module mac_operand_sequencer_sync_fifo
   import mac_operand_sequencer_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        push_i,
   input  fifo_entry_t wdata_i,
   input  logic        pop_i,
   output fifo_entry_t rdata_o,
   output logic        full_o,
   output logic        empty_o
);
   localparam int PTR_W = $clog2(DEPTH);

   fifo_entry_t      mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign rdata_o = mem_q[rd_ptr_q];

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
      end
   end
endmodule

// File: rtl/mac_operand_sequencer.sv
// Feeds the MAC fixed-length accumulation groups from a buffered operand stream,
// zero-padding the final group of each frame.
//
//   state | meaning
//   IDLE  | between frames, slot is 0
//   RUN   | inside a frame, issuing operand pairs (bubble when FIFO empty)
//   PAD   | frame ended early in a group, issuing zero slots until its last slot
module mac_operand_sequencer
   import mac_operand_sequencer_pkg::*;
(
   input  logic                    clk_i,
   input  logic                    rst_ni,
   mac_operand_sequencer_if.slave  bus
);
   localparam int                SLOT_W    = $clog2(GROUP_LEN);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(GROUP_LEN - 1);

   fifo_entry_t       head;
   fifo_entry_t       wr_entry;
   logic              fifo_full;
   logic              fifo_empty;
   logic              push;
   logic              pop;
   logic              slot_end;
   logic [SLOT_W-1:0] slot_d;

   seq_state_t        state_q;
   logic [SLOT_W-1:0] slot_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic              ce_q;
   logic              first_q;
   logic              last_q;
   logic              done_q;

   assign bus.in_ready = rst_ni && !fifo_full;
   assign push         = bus.in_valid && bus.in_ready;
   assign pop          = !bus.out_stall && !fifo_empty && (state_q != PAD);
   assign wr_entry     = '{last: bus.in_last, a: bus.in_a, b: bus.in_b};
   assign slot_end     = (slot_q == SLOT_LAST);
   assign slot_d       = slot_end ? '0 : slot_q + 1'b1;

   mac_operand_sequencer_sync_fifo u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push),
      .wdata_i (wr_entry),
      .pop_i   (pop),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         slot_q  <= '0;
         a_q     <= '0;
         b_q     <= '0;
         ce_q    <= 1'b0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         ce_q    <= 1'b0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
         if (!bus.out_stall) begin
            unique case (state_q)
               IDLE, RUN: begin
                  if (!fifo_empty) begin
                     a_q     <= head.a;
                     b_q     <= head.b;
                     ce_q    <= 1'b1;
                     first_q <= (slot_q == '0);
                     last_q  <= slot_end;
                     slot_q  <= slot_d;
                     if (head.last && slot_end) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                     end else if (head.last) begin
                        state_q <= PAD;
                     end else begin
                        state_q <= RUN;
                     end
                  end
               end
               PAD: begin
                  a_q     <= '0;
                  b_q     <= '0;
                  ce_q    <= 1'b1;
                  first_q <= (slot_q == '0);
                  last_q  <= slot_end;
                  slot_q  <= slot_d;
                  if (slot_end) begin
                     done_q  <= 1'b1;
                     state_q <= IDLE;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus.a          = a_q;
   assign bus.b          = b_q;
   assign bus.ce         = ce_q;
   assign bus.grp_first  = first_q;
   assign bus.grp_last   = last_q;
   assign bus.frame_done = done_q;
endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Randomized bench for mac_operand_sequencer with a frame-level slot-list reference model.
module tb_mac_operand_sequencer;
   import mac_operand_sequencer_pkg::*;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        last;
   } pair_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        first;
      logic        last;
      logic        done;
      logic        pad;
   } slot_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mac_operand_sequencer_if bus();

   mac_operand_sequencer dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   pair_t       pend[$];
   slot_t       exp_q[$];
   int          occ      = 0;
   int          mslot    = 0;
   int          ce_cnt   = 0;
   int          acc_cnt  = 0;
   logic [15:0] last_a   = '0;
   logic [15:0] last_b   = '0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Every accepted pair becomes one slot; a frame's last pair appends zero slots up to the group end.
   task automatic model_accept(input pair_t p);
      slot_t s;
      s.a = p.a; s.b = p.b; s.pad = 1'b0;
      s.first = (mslot == 0);
      s.last  = (mslot == GROUP_LEN - 1);
      s.done  = p.last && s.last;
      exp_q.push_back(s);
      occ++;
      mslot = (mslot + 1) % GROUP_LEN;
      if (p.last) begin
         while (mslot != 0) begin
            s.a = '0; s.b = '0; s.pad = 1'b1; s.first = 1'b0;
            s.last = (mslot == GROUP_LEN - 1);
            s.done = s.last;
            exp_q.push_back(s);
            mslot = (mslot + 1) % GROUP_LEN;
         end
      end
   endtask

   task automatic cycle(input bit want_valid, input bit stall, input bit rst);
      bit    acc, avail, st, rs;
      pair_t p;
      slot_t s;
      rst_n         = rst;
      bus.out_stall = stall;
      if (want_valid && pend.size() > 0) begin
         p            = pend[0];
         bus.in_valid = 1'b1;
         bus.in_a     = p.a;
         bus.in_b     = p.b;
         bus.in_last  = p.last;
      end else begin
         bus.in_valid = 1'b0;
         bus.in_a     = 16'($urandom);
         bus.in_b     = 16'($urandom);
         bus.in_last  = 1'($urandom);
      end
      @(negedge clk);
      check_val("in_ready", {31'd0, bus.in_ready}, {31'd0, (rst && occ < DEPTH)});
      acc   = bus.in_valid && bus.in_ready;
      avail = exp_q.size() > 0;
      st    = stall;
      rs    = rst;
      if (acc) begin
         void'(pend.pop_front());
         acc_cnt++;
      end
      @(posedge clk);
      #1;
      if (!rs) begin
         exp_q.delete();
         pend.delete();
         occ = 0; mslot = 0; last_a = '0; last_b = '0;
      end else if (acc) begin
         model_accept(p);
      end
      check_val("ce", {31'd0, bus.ce}, {31'd0, (rs && !st && avail)});
      if (bus.ce === 1'b1) begin
         ce_cnt++;
         if (exp_q.size() > 0) begin
            s = exp_q.pop_front();
            if (!s.pad) occ--;
            check_val("slot_a", {16'd0, bus.a}, {16'd0, s.a});
            check_val("slot_b", {16'd0, bus.b}, {16'd0, s.b});
            check_val("flags_first_last_done", {29'd0, bus.grp_first, bus.grp_last, bus.frame_done},
                      {29'd0, s.first, s.last, s.done});
         end
         last_a = bus.a;
         last_b = bus.b;
      end else begin
         check_val("hold_ab", {bus.a, bus.b}, {last_a, last_b});
         check_val("idle_flags", {29'd0, bus.grp_first, bus.grp_last, bus.frame_done}, 32'd0);
      end
   endtask

   task automatic add_pair(input logic [15:0] a, input logic [15:0] b, input logic last);
      pair_t p;
      p.a = a; p.b = b; p.last = last;
      pend.push_back(p);
   endtask

   task automatic add_frame(input int n);
      for (int i = 0; i < n; i++) add_pair(16'($urandom), 16'($urandom), i == n - 1);
   endtask

   task automatic drain(input int max_cycles);
      int n = 0;
      while ((pend.size() > 0 || exp_q.size() > 0) && n < max_cycles) begin
         cycle(1'b1, 1'b0, 1'b1);
         n++;
      end
      check_val("drain_done", 32'(pend.size() + exp_q.size()), 32'd0);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_last   = 1'b0;
      bus.out_stall = 1'b0;
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b1);

      // full group with no padding
      ce_cnt = 0;
      add_pair(16'd1, 16'd2, 1'b0);
      add_pair(16'd3, 16'd4, 1'b0);
      add_pair(16'd5, 16'd6, 1'b0);
      add_pair(16'd7, 16'd8, 1'b1);
      drain(40);
      check_val("t1_slots", 32'(ce_cnt), 32'd4);

      // single pair, three pad slots
      ce_cnt = 0;
      add_pair(16'd9, 16'd9, 1'b1);
      drain(40);
      check_val("t2_slots", 32'(ce_cnt), 32'd4);

      // six pairs: one full group, one padded group
      ce_cnt = 0;
      add_frame(6);
      drain(40);
      check_val("t3_slots", 32'(ce_cnt), 32'd8);

      // stall three cycles mid-group
      ce_cnt = 0;
      add_frame(8);
      for (int i = 0; i < 12; i++) cycle(1'b1, (i >= 3 && i < 6), 1'b1);
      drain(40);
      check_val("t4_slots", 32'(ce_cnt), 32'd8);

      // fill under stall: only DEPTH pairs accepted
      acc_cnt = 0;
      ce_cnt  = 0;
      add_frame(12);
      for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b1);
      check_val("t5_accepts", 32'(acc_cnt), 32'(DEPTH));
      drain(80);
      check_val("t5_slots", 32'(ce_cnt), 32'd12);

      // reset after two slots of a group
      ce_cnt = 0;
      add_frame(4);
      for (int i = 0; i < 20 && ce_cnt < 2; i++) cycle(1'b1, 1'b0, 1'b1);
      check_val("t6_two_slots", 32'(ce_cnt), 32'd2);
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b1);
      check_val("t6_no_pad_after_rst", 32'(ce_cnt), 32'd2);
      add_frame(3);
      drain(40);

      // random frames, random valid and stall
      for (int i = 0; i < 400; i++) begin
         if (pend.size() < 4) add_frame($urandom_range(1, 10));
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 1'b1);
      end
      drain(300);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
